// File: rtl/array_multiplier.sv
// Unsigned N x N array multiplier (AND partial-product rows summed by ripple full-adder rows) with a registered 2N-bit product.
// Latency: 1 cycle from an accepted pair (in_valid=1) to p/out_valid.
// Backpressure: none; accepts one pair per cycle; p holds its value while in_valid is low.
module array_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p,
    output logic           out_valid
);

    logic [2*N-1:0] acc;
    logic           carry;
    logic           pp_bit;
    logic           sum;

    logic [2*N-1:0] p_d, p_q;
    logic           out_valid_d, out_valid_q;

    // Row 0 seeds the accumulator. Each later row i adds (a & b[i]) at bit
    // offset i through a ripple chain of full adders; its carry-out lands in bit i+N.
    always_comb begin
        acc    = '0;
        carry  = 1'b0;
        pp_bit = 1'b0;
        sum    = 1'b0;
        for (int j = 0; j < N; j++) begin
            acc[j] = a[j] & b[0];
        end
        for (int i = 1; i < N; i++) begin
            carry = 1'b0;
            for (int j = 0; j < N; j++) begin
                pp_bit     = a[j] & b[i];
                sum        = acc[i+j] ^ pp_bit ^ carry;
                carry      = (acc[i+j] & pp_bit) | (acc[i+j] & carry) | (pp_bit & carry);
                acc[i+j]   = sum;
            end
            acc[i+N] = carry;
        end
    end

    always_comb begin
        p_d         = in_valid ? acc : p_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier.sv
// Directed and random checks of array_multiplier at N=4, 8 and 16 against hand-computed products.
module tb_array_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        v4, v8, v16;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [31:0] p16;
    logic        ov4, ov8, ov16;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    array_multiplier #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .p(p4), .out_valid(ov4)
    );
    array_multiplier #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .p(p8), .out_valid(ov8)
    );
    array_multiplier #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .p(p16), .out_valid(ov16)
    );

    // Presents inputs to the selected instance (others idle) and advances one rising edge.
    task automatic drive(input int w, input logic r, input logic v,
                         input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        rst = r;
        v4  = 1'b0;
        v8  = 1'b0;
        v16 = 1'b0;
        case (w)
            4: begin v4 = v; a4 = av[3:0]; b4 = bv[3:0]; end
            8: begin v8 = v; a8 = av[7:0]; b8 = bv[7:0]; end
            default: begin v16 = v; a16 = av; b16 = bv; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int w, input string tag,
                         input logic [63:0] exp_p, input logic exp_v);
        logic [63:0] obs_p;
        logic        obs_v;
        case (w)
            4:       begin obs_p = {56'd0, p4};  obs_v = ov4;  end
            8:       begin obs_p = {48'd0, p8};  obs_v = ov8;  end
            default: begin obs_p = {32'd0, p16}; obs_v = ov16; end
        endcase
        n_assert++;
        assert (obs_p === exp_p) else begin
            n_fail++;
            $error("FAIL %s N=%0d p observed=%0d expected=%0d", tag, w, obs_p, exp_p);
        end
        n_assert++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s N=%0d out_valid observed=%0b expected=%0b", tag, w, obs_v, exp_v);
        end
    endtask

    logic [15:0] ta [0:7];
    logic [15:0] tb_ [0:7];
    logic [63:0] tp [0:7];
    logic [15:0] ra, rb;
    logic [63:0] ref_p;

    initial begin
        rst = 1'b1;
        v4 = 1'b1; v8 = 1'b1; v16 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; a8 = 8'hFF; b8 = 8'hFF; a16 = 16'hFFFF; b16 = 16'hFFFF;

        // Reset held two edges with a valid all-ones pair present: must be discarded.
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            rst = 1'b1;
            v4 = 1'b1; v8 = 1'b1; v16 = 1'b1;
            @(posedge clk);
            #1;
            check(4,  "reset", 64'd0, 1'b0);
            check(8,  "reset", 64'd0, 1'b0);
            check(16, "reset", 64'd0, 1'b0);
        end

        // N=8 directed, back-to-back.
        ta[0]=0;   tb_[0]=0;   tp[0]=0;
        ta[1]=1;   tb_[1]=1;   tp[1]=1;
        ta[2]=3;   tb_[2]=5;   tp[2]=15;
        ta[3]=15;  tb_[3]=15;  tp[3]=225;
        ta[4]=255; tb_[4]=1;   tp[4]=255;
        ta[5]=255; tb_[5]=255; tp[5]=65025;
        ta[6]=0;   tb_[6]=200; tp[6]=0;
        ta[7]=1;   tb_[7]=173; tp[7]=173;
        for (int k = 0; k < 8; k++) begin
            drive(8, 1'b0, 1'b1, ta[k], tb_[k]);
            check(8, "dir8", tp[k], 1'b1);
        end

        // Hold: one valid pair then three idle edges with operands wiggling.
        drive(8, 1'b0, 1'b1, 16'd3, 16'd5);
        check(8, "hold_acc", 64'd15, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(8, 1'b0, 1'b0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
            check(8, "hold_idle", 64'd15, 1'b0);
        end

        // Mid-stream reset discards the pair presented on its edge.
        drive(8, 1'b0, 1'b1, 16'd7, 16'd9);
        check(8, "stream_a", 64'd63, 1'b1);
        drive(8, 1'b0, 1'b1, 16'd12, 16'd12);
        check(8, "stream_b", 64'd144, 1'b1);
        drive(8, 1'b1, 1'b1, 16'd200, 16'd200);
        check(8, "mid_rst", 64'd0, 1'b0);
        drive(8, 1'b0, 1'b0, 16'd200, 16'd200);
        check(8, "post_rst_idle", 64'd0, 1'b0);
        drive(8, 1'b0, 1'b1, 16'd6, 16'd7);
        check(8, "post_rst_first", 64'd42, 1'b1);

        // N=4 directed.
        ta[0]=0;  tb_[0]=0;  tp[0]=0;
        ta[1]=1;  tb_[1]=1;  tp[1]=1;
        ta[2]=3;  tb_[2]=5;  tp[2]=15;
        ta[3]=15; tb_[3]=15; tp[3]=225;
        ta[4]=15; tb_[4]=1;  tp[4]=15;
        ta[5]=1;  tb_[5]=11; tp[5]=11;
        ta[6]=9;  tb_[6]=0;  tp[6]=0;
        ta[7]=12; tb_[7]=10; tp[7]=120;
        for (int k = 0; k < 8; k++) begin
            drive(4, 1'b0, 1'b1, ta[k], tb_[k]);
            check(4, "dir4", tp[k], 1'b1);
        end

        // N=16 directed.
        ta[0]=0;     tb_[0]=0;     tp[0]=0;
        ta[1]=1;     tb_[1]=1;     tp[1]=1;
        ta[2]=3;     tb_[2]=5;     tp[2]=15;
        ta[3]=255;   tb_[3]=255;   tp[3]=65025;
        ta[4]=65535; tb_[4]=1;     tp[4]=65535;
        ta[5]=65535; tb_[5]=65535; tp[5]=64'd4294836225;
        ta[6]=1234;  tb_[6]=5678;  tp[6]=7006652;
        ta[7]=0;     tb_[7]=40000; tp[7]=0;
        for (int k = 0; k < 8; k++) begin
            drive(16, 1'b0, 1'b1, ta[k], tb_[k]);
            check(16, "dir16", tp[k], 1'b1);
        end

        // Random streams, continuous in_valid, for each width.
        for (int k = 0; k < 120; k++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            ref_p = {48'd0, ra} * {48'd0, rb};
            drive(8, 1'b0, 1'b1, ra, rb);
            check(8, "rand8", ref_p, 1'b1);
        end
        for (int k = 0; k < 120; k++) begin
            ra = 16'($urandom_range(0, 15));
            rb = 16'($urandom_range(0, 15));
            ref_p = {48'd0, ra} * {48'd0, rb};
            drive(4, 1'b0, 1'b1, ra, rb);
            check(4, "rand4", ref_p, 1'b1);
        end
        for (int k = 0; k < 120; k++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            ref_p = {48'd0, ra} * {48'd0, rb};
            drive(16, 1'b0, 1'b1, ra, rb);
            check(16, "rand16", ref_p, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/array_multiplier.md
ARRAY_MULTIPLIER -- requirements
Module: array_multiplier

Interface
REQ-001 Parameter N, default 8, operand width in bits; SHALL support any N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  a/b hold a valid operand pair this cycle.
REQ-005 a  input  N  multiplicand, unsigned.
REQ-006 b  input  N  multiplier, unsigned.
REQ-007 p  output  2N  registered product, unsigned.
REQ-008 out_valid  output  1  p holds the product of a pair accepted on the previous edge.

Function
REQ-009 Product SHALL be computed combinationally by an N x N array: partial product row i = a AND b[i], shifted left i; rows summed by full/half-adder cells (ripple or carry-save rows with a final ripple adder); no "*" operator in the datapath.
REQ-010 Arithmetic SHALL be unsigned; result width 2N; p SHALL equal a*b exactly, with no truncation or overflow for any operands.
REQ-011 Latency SHALL be 1 cycle: on a rising edge with rst=0 and in_valid=1, p <= a*b of the values present at that edge, and out_valid <= 1.
REQ-012 On a rising edge with rst=0 and in_valid=0, p SHALL hold its previous value and out_valid <= 0.
REQ-013 Throughput SHALL be one product per cycle; back-to-back in_valid pulses SHALL each produce their own result one cycle later.
REQ-014 No internal state other than the p and out_valid registers; no state machine.
REQ-015 Boundary: a=0 or b=0 -> p=0; a=1 -> p=b; a=b=2^N-1 -> p=(2^N-1)^2 (for N=8: 65025 = 0xFE01).
REQ-016 Operand X/changes between edges SHALL not affect p until the next accepting edge.

Reset
REQ-017 When rst=1 at a rising edge, p <= 0 and out_valid <= 0, regardless of in_valid.
REQ-018 rst SHALL take priority over in_valid; a pair presented on a reset edge is discarded and produces no result.
REQ-019 Reset asserted mid-stream SHALL clear p/out_valid on that edge; the first valid pair after rst deasserts produces its result one cycle later with no extra warm-up.
REQ-020 Before the first reset p and out_valid are undefined; the bench SHALL apply rst for at least one edge.

Verification
REQ-021 rst=1 for 2 edges, in_valid=1, a=255, b=255 -> p=0, out_valid=0 after each edge.
REQ-022 Directed N=8, one pair per cycle: (0,0)->0, (1,1)->1, (3,5)->15, (15,15)->225, (255,1)->255, (255,255)->65025; each p valid with out_valid=1 exactly one edge after presentation.
REQ-023 in_valid=1 with (3,5) then in_valid=0 for 3 edges -> p stays 15, out_valid=1 then 0,0,0.
REQ-024 Stream (7,9),(12,12) then assert rst on the edge presenting (200,200) -> outputs 63, 144, then p=0/out_valid=0; (200,200) never appears.
REQ-025 At least 100 random unsigned pairs in [0, 2^N-1], continuous in_valid -> every p equals reference a*b one cycle later; bench SHALL report pass/fail counts and zero failures.
REQ-026 Repeat REQ-022 and random test with N=4 and N=16 -> exact products, e.g. N=4 (15,15)->225, N=16 (65535,65535)->4294836225.
